// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start / fade sequencer feeding the downstream PWM
// generator's uptime/cs inputs. Moves the duty value one LSB per step,
// with steps paced in whole PWM frames.
// Optional feature macro: PWM_RAMP_RETARGET_EN (start during a ramp reloads
// the target).
module pwm_ramp_ctrl #(
    parameter int WIDTH       = 3,
    parameter int PERIOD      = 8,
    parameter int STEP_FRAMES = 4
) (
    input  logic             clkin,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             abort,
    output logic [WIDTH-1:0] uptime,
    output logic             cs,
    output logic             busy,
    output logic             done
);

    localparam int FW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [FW-1:0]    frame_cnt;
    logic             tick;
    logic [SW-1:0]    step_cnt, step_nxt;
    logic [WIDTH-1:0] cur, cur_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic             cs_nxt, done_nxt;

    assign tick   = (frame_cnt == FRAME_LAST);
    assign uptime = cur;
    assign busy   = (state == RAMP);

    // Free-running frame counter mirroring the downstream PWM counter phase.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    // State, duty value, target, step pacing and registered pulses.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            step_cnt <= '0;
            cur      <= '0;
            tgt      <= '0;
            cs       <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_nxt;
            cur      <= cur_nxt;
            tgt      <= tgt_nxt;
            cs       <= cs_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state logic: command acceptance, abort, frame-paced stepping.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        cur_nxt   = cur;
        tgt_nxt   = tgt;
        cs_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tgt_nxt = target;
                    if (target == cur) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RAMP;
                        step_nxt  = '0;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
`ifdef PWM_RAMP_RETARGET_EN
                    // A retarget on a step edge steers that step toward the new target.
                    if (start) begin
                        tgt_nxt = target;
                    end
                    if (start && (target == cur)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else
`endif
                    if (tick) begin
                        if (step_cnt == STEP_LAST) begin
                            step_nxt = '0;
                            cs_nxt   = 1'b1;
                            if (cur < tgt_nxt) begin
                                cur_nxt = cur + WIDTH'(1);
                            end else begin
                                cur_nxt = cur - WIDTH'(1);
                            end
                            if (cur_nxt == tgt_nxt) begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            step_nxt = step_cnt + SW'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed scenarios plus randomized commands, checked
// every cycle against a behavioural model of the ramp sequencer.
module tb_pwm_ramp_ctrl;

    localparam int W  = 3;
    localparam int P  = 8;
    localparam int SF = 4;

    logic         clkin  = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic         abort  = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] uptime;
    logic         cs;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_cur   = 0;
    int m_tgt   = 0;
    int m_ticks = 0;
    int m_cyc   = 0;
    bit m_busy  = 0;
    bit m_cs    = 0;
    bit m_done  = 0;

    int ncyc = 0;
    int ups[$];
    int last_cs;

    pwm_ramp_ctrl #(.WIDTH(W), .PERIOD(P), .STEP_FRAMES(SF)) dut (
        .clkin  (clkin),
        .resetn (resetn),
        .start  (start),
        .target (target),
        .abort  (abort),
        .uptime (uptime),
        .cs     (cs),
        .busy   (busy),
        .done   (done)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the sequencer described in terms of frames and steps.
    task automatic model_edge(input bit s, input int t, input bit a);
        bit tk;
        tk     = (m_cyc % P) == (P - 1);
        m_cs   = 0;
        m_done = 0;
        if (!m_busy) begin
            if (s) begin
                m_tgt = t;
                if (t == m_cur) m_done = 1;
                else begin
                    m_busy  = 1;
                    m_ticks = 0;
                end
            end
        end else if (a) begin
            m_busy = 0;
        end else begin
`ifdef PWM_RAMP_RETARGET_EN
            if (s) m_tgt = t;
            if (s && t == m_cur) begin
                m_busy = 0;
                m_done = 1;
                tk     = 0;
            end
`endif
            if (tk) begin
                m_ticks++;
                if (m_ticks % SF == 0) begin
                    m_cur = (m_cur < m_tgt) ? m_cur + 1 : m_cur - 1;
                    m_cs  = 1;
                    if (m_cur == m_tgt) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
        m_cyc++;
    endtask

    task automatic cyc(input bit s, input int t, input bit a);
        start  = s;
        target = t[W-1:0];
        abort  = a;
        @(posedge clkin);
        model_edge(s, t, a);
        @(negedge clkin);
        ncyc++;
        check("uptime", uptime, m_cur);
        check("cs", cs, m_cs);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        start = 0;
        abort = 0;
    endtask

    task automatic do_reset();
        @(negedge clkin);
        #2 resetn = 0;
        #1;
        check("rst_uptime", uptime, 0);
        check("rst_cs", cs, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clkin);
        resetn  = 1;
        m_cur   = 0;
        m_tgt   = 0;
        m_ticks = 0;
        m_cyc   = 0;
        m_busy  = 0;
        m_cs    = 0;
        m_done  = 0;
    endtask

    // Issue a start and follow the ramp to its end, recording cs uptimes.
    task automatic run_ramp(input int t);
        ups.delete();
        last_cs = -1;
        cyc(1, t, 0);
        for (int i = 0; i < 400; i++) begin
            cyc(0, 0, 0);
            if (cs === 1'b1) begin
                ups.push_back(int'(uptime));
                if (last_cs >= 0) check("cs_spacing", ncyc - last_cs, P * SF);
                last_cs = ncyc;
            end
            if (done === 1'b1 || busy !== 1'b1) break;
        end
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("init_uptime", uptime, 0);
        check("init_busy", busy, 0);
        @(negedge clkin);
        @(negedge clkin);
        resetn = 1;

        // ramp up 0 -> 5
        run_ramp(5);
        check("up_count", ups.size(), 5);
        for (int k = 0; k < ups.size() && k < 5; k++) check("up_val", ups[k], k + 1);
        check("up_done_cs", cs, 1);
        check("up_done_busy", busy, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);

        // ramp down 5 -> 2
        run_ramp(2);
        check("dn_count", ups.size(), 3);
        for (int k = 0; k < ups.size() && k < 3; k++) check("dn_val", ups[k], 4 - k);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0);

        // null command at cur=3
        run_ramp(3);
        cyc(0, 0, 0);
        cyc(1, 3, 0);
        check("null_done", done, 1);
        check("null_busy", busy, 0);
        check("null_cs", cs, 0);
        cyc(0, 0, 0);
        check("null_done_once", done, 0);

        // asynchronous reset mid-ramp
        cyc(1, 7, 0);
        for (int i = 0; i < 45; i++) cyc(0, 0, 0);
        do_reset();

        // abort after the second step
        cyc(1, 7, 0);
`ifndef PWM_RAMP_RETARGET_EN
        cyc(1, 0, 0);
`endif
        ups.delete();
        for (int i = 0; i < 200 && ups.size() < 2; i++) begin
            cyc(0, 0, 0);
            if (cs === 1'b1) ups.push_back(int'(uptime));
        end
        check("ab_steps", ups.size(), 2);
        cyc(0, 0, 1);
        check("ab_busy", busy, 0);
        check("ab_uptime", uptime, 2);
        check("ab_done", done, 0);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0);
        check("ab_hold", uptime, 2);

`ifdef PWM_RAMP_RETARGET_EN
        do_reset();
        cyc(1, 6, 0);
        ups.delete();
        for (int i = 0; i < 200 && ups.size() < 2; i++) begin
            cyc(0, 0, 0);
            if (cs === 1'b1) ups.push_back(int'(uptime));
        end
        cyc(1, 1, 0);
        for (int i = 0; i < 100 && cs !== 1'b1; i++) cyc(0, 0, 0);
        check("rt_uptime", uptime, 1);
        check("rt_done", done, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
`endif

        // randomized commands
        for (int i = 0; i < 3000; i++) begin
            bit s, a;
            int t;
            s = m_busy ? ($urandom % 16 == 0) : ($urandom % 6 == 0);
            a = ($urandom % 64 == 0);
            t = int'($urandom % (1 << W));
            cyc(s, t, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start / fade sequencer that sits directly upstream of the 3-bit PWM generator. It drives that block's `uptime` and `cs` inputs. On command it steps the duty value one LSB at a time toward a requested target, issuing one `cs` write strobe per step. Steps are paced in whole PWM frames, so every duty change lands cleanly on the downstream generator.

Parameters:
- WIDTH, 3, duty-value width; must match the downstream uptime width.
- PERIOD, 8, clock cycles per PWM frame; equals 2^WIDTH of the downstream free-running counter; legal values ≥2.
- STEP_FRAMES, 4, PWM frames between successive duty steps; legal values ≥1.

Ports:
- clkin  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; latches target.
- target  input  WIDTH  requested final duty value, sampled when start is accepted.
- abort  input  1  stops an active ramp; the duty value holds.
- uptime  output  WIDTH  current duty value; connects to downstream uptime.
- cs  output  1  one-cycle write strobe; connects to downstream cs.
- busy  output  1  high while a ramp is in progress.
- done  output  1  one-cycle pulse when the duty value reaches target.

Behaviour:
- Reset (resetn low, asynchronous):
  - frame_cnt=0, step_cnt=0, cur=0, tgt=0, state=IDLE.
  - Outputs: uptime=0, cs=0, busy=0, done=0.
- frame_cnt:
  - Free-runs 0..PERIOD-1 and wraps, from reset release, independent of state.
  - tick = (frame_cnt==PERIOD-1).
- uptime is driven directly from register cur. cs and done are registered pulses.
- States: IDLE, RAMP. busy = (state==RAMP).
- IDLE, start=1:
  - tgt<=target.
  - If target==cur: stay in IDLE; done=1 next cycle; no cs.
  - Otherwise: state<=RAMP, step_cnt<=0.
- RAMP, on each tick:
  - If step_cnt==STEP_FRAMES-1: step_cnt<=0, and perform a step:
    - cur<=cur+1 if cur<tgt, else cur<=cur-1.
    - cs<=1 for one cycle. cs rises on the same edge that updates cur, so uptime is valid whenever cs=1.
  - Otherwise: step_cnt<=step_cnt+1.
- Step reaches target: if the new cur equals tgt, then on the same edge state<=IDLE and done<=1. done coincides with the final cs.
- First step timing: occurs on the STEP_FRAMES-th tick strictly after the cycle start was accepted. A tick in the start cycle itself is not counted.
- Step spacing: exactly PERIOD*STEP_FRAMES cycles between consecutive cs pulses.
- cur moves only ±1 per step, with no wrap. Arithmetic is WIDTH-bit unsigned.
- abort in RAMP: state<=IDLE next edge, cur holds, no cs, no done.
  - abort has priority over a simultaneous step.
  - abort in IDLE is ignored.
- start in RAMP: ignored. tgt is unchanged (see the optional feature).
- start and abort in the same cycle in IDLE: abort ignored, start processed.
- resetn asserted mid-ramp: all state returns to reset values immediately; cs deasserts asynchronously.

Optional Feature:
- Macro: PWM_RAMP_RETARGET_EN.
- Defined: start in RAMP reloads tgt<=target; step_cnt is unchanged.
  - If the new target equals cur: state<=IDLE and done<=1 next edge, no cs.
  - Otherwise ramping continues toward the new target, with direction re-evaluated at each step.
- Not defined: start in RAMP is ignored, as stated under Behaviour.

Test Plan:
- Reset check: drive resetn low mid-operation → uptime=0, cs=0, busy=0, done=0 immediately. After release, frame_cnt wraps every 8 cycles.
- Ramp up (defaults): start with target=5 from cur=0 → exactly 5 cs pulses with uptime=1,2,3,4,5, spaced 32 cycles apart. done coincides with the 5th cs; busy falls the same edge.
- Ramp down: from cur=5, start with target=2 → cs pulses with uptime=4,3,2; done on the last; no further cs.
- Null command: start with target equal to cur (3) → done pulses one cycle later; busy and cs stay 0.
- Abort: start target=7 from cur=0, assert abort after the 2nd cs → busy=0 next cycle, uptime holds at 2, no done. A start during RAMP is ignored (macro undefined).
- Retarget (PWM_RAMP_RETARGET_EN defined): start target=6 from cur=0, then after the 2nd cs, start target=1 → next cs shows uptime=1 and done pulses with it.
